// File: rtl/power_spectrum_framer.sv
// Purpose: turns the complex FFT bin stream into the one-sided power spectrum (re^2+im^2)>>POWER_SHIFT.
// Latency: two register stages; a beat accepted in cycle c is presented on the output in cycle c+2.
// Backpressure: one global enable; while the output is valid and not taken, every stage holds and input ready drops.
module power_spectrum_framer #(
   parameter int N_FFT       = 512,
   parameter int POWER_SHIFT = 0
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [31:0] fft_data_in,
   input  logic        fft_valid_in,
   input  logic        fft_last_in,
   output logic        fft_ready_out,
   output logic [31:0] power_data_out,
   output logic        power_valid_out,
   output logic        power_last_out,
   input  logic        power_ready_in,
   input  logic        err_clear_in,
   output logic        frame_error_out,
   output logic [15:0] frame_count_out
);

   localparam int            KW     = $clog2(N_FFT);
   localparam logic [KW-1:0] K_HALF = KW'(N_FFT / 2);
   localparam logic [KW-1:0] K_MAX  = KW'(N_FFT - 1);

   logic              en;
   logic              accept;
   logic              fwd;
   logic signed [31:0] re_x;
   logic signed [31:0] im_x;
   logic [31:0]       re2;
   logic [31:0]       im2;
   logic [31:0]       pwr;

   logic [KW-1:0]     k_q, k_d;
   logic              err_q, err_d;
   logic [15:0]       fcnt_q, fcnt_d;
   logic              s1_vld_q, s1_vld_d;
   logic              s1_last_q, s1_last_d;
   logic [31:0]       s1_re2_q, s1_re2_d;
   logic [31:0]       s1_im2_q, s1_im2_d;
   logic              out_vld_q, out_vld_d;
   logic              out_last_q, out_last_d;
   logic [31:0]       out_dat_q, out_dat_d;

   // A stalled output freezes the whole pipe; ready is held low during reset.
   assign en            = !out_vld_q || power_ready_in;
   assign fft_ready_out = en && rst_n_in;
   assign accept        = fft_valid_in && fft_ready_out;
   assign fwd           = (k_q <= K_HALF);

   // Squares as full signed products; (-32768)^2 = 2^30 still fits, so the 32-bit result is exact.
   always_comb begin
      re_x = {{16{fft_data_in[31]}}, fft_data_in[31:16]};
      im_x = {{16{fft_data_in[15]}}, fft_data_in[15:0]};
      re2  = 32'(re_x * re_x);
      im2  = 32'(im_x * im_x);
      pwr  = (s1_re2_q + s1_im2_q) >> POWER_SHIFT;
   end

   // Bin counter and sticky frame-length error; a set event beats a same-cycle clear.
   always_comb begin
      k_d   = k_q;
      err_d = err_q;
      if (err_clear_in) begin
         err_d = 1'b0;
      end
      if (accept) begin
         if (fft_last_in) begin
            k_d = '0;
            if (k_q != K_MAX) begin
               err_d = 1'b1;
            end
         end else if (k_q == K_MAX) begin
            // Overlong frame: resynchronise so the next beat is bin 0.
            k_d   = '0;
            err_d = 1'b1;
         end else begin
            k_d = k_q + KW'(1);
         end
      end
   end

   // Pipeline stages; upper-half bins become bubbles in S1 rather than being skipped.
   always_comb begin
      s1_vld_d   = s1_vld_q;
      s1_last_d  = s1_last_q;
      s1_re2_d   = s1_re2_q;
      s1_im2_d   = s1_im2_q;
      out_vld_d  = out_vld_q;
      out_last_d = out_last_q;
      out_dat_d  = out_dat_q;
      if (en) begin
         s1_vld_d   = accept && fwd;
         s1_last_d  = fft_last_in || (k_q == K_HALF);
         s1_re2_d   = re2;
         s1_im2_d   = im2;
         out_vld_d  = s1_vld_q;
         out_last_d = s1_vld_q && s1_last_q;
         out_dat_d  = pwr;
      end
   end

   // Completed frames are counted when the last beat is actually taken downstream.
   always_comb begin
      fcnt_d = fcnt_q;
      if (out_vld_q && power_ready_in && out_last_q) begin
         fcnt_d = fcnt_q + 16'd1;
      end
   end

   // State register; asynchronous reset discards anything in flight.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         k_q        <= '0;
         err_q      <= 1'b0;
         fcnt_q     <= '0;
         s1_vld_q   <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_re2_q   <= '0;
         s1_im2_q   <= '0;
         out_vld_q  <= 1'b0;
         out_last_q <= 1'b0;
         out_dat_q  <= '0;
      end else begin
         k_q        <= k_d;
         err_q      <= err_d;
         fcnt_q     <= fcnt_d;
         s1_vld_q   <= s1_vld_d;
         s1_last_q  <= s1_last_d;
         s1_re2_q   <= s1_re2_d;
         s1_im2_q   <= s1_im2_d;
         out_vld_q  <= out_vld_d;
         out_last_q <= out_last_d;
         out_dat_q  <= out_dat_d;
      end
   end

   assign power_data_out  = out_dat_q;
   assign power_valid_out = out_vld_q;
   assign power_last_out  = out_last_q;
   assign frame_error_out = err_q;
   assign frame_count_out = fcnt_q;

endmodule
